// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   Two-to-one OBI arbiter sharing one single-ported memory between the
//   core's instruction port (requester 0) and data port (requester 1).
//   The address phase is muxed combinationally; an in-order ID FIFO steers
//   each response back to the requester that issued the transaction.
//
// Build option:
//   OBI_ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the requester opposite
//                                        the last granted one
//                           undefined -> fixed priority, requester 1 wins ties
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   mX_req_i / mX_gnt_o    requester X address-phase handshake
//   mX_addr_i/we/be/wdata  requester X address-phase fields
//   mX_rvalid_o/rdata_o    requester X response (rdata is s_rdata_i as-is)
//   s_*                    subordinate (memory) side of the bus
//   err_o                  sticky: response arrived with no transaction pending

module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,

    output logic        err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic                       r_lock;
    logic                       r_lock_id;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_err;

    logic w_full;
    logic w_tie_id;
    logic w_sel;
    logic w_push;
    logic w_pop;
    logic w_head;

    // ---------------------------------------------------------------
    // Tie-break policy
    // ---------------------------------------------------------------
`ifdef OBI_ARB_ROUND_ROBIN_EN
    logic r_last_id;

    // Reset value 0 makes the first tie go to requester 1.
    assign w_tie_id = ~r_last_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     r_last_id <= 1'b0;
        else if (w_push) r_last_id <= w_sel;
    end
`else
    assign w_tie_id = 1'b1;
`endif

    // ---------------------------------------------------------------
    // Selection and address phase
    // ---------------------------------------------------------------
    assign w_full = (r_count == FULL_CNT);

    // A pending ungranted request keeps the mux frozen so the address
    // phase seen by the memory stays stable until it is accepted.
    always_comb begin
        w_sel = w_tie_id;
        if (r_lock)                  w_sel = r_lock_id;
        else if (m0_req_i ^ m1_req_i) w_sel = m1_req_i;
    end

    // Full gates the request even when a pop happens this cycle; the slot
    // freed by the pop is only usable from the next cycle on.
    assign s_req_o   = (m0_req_i | m1_req_i) & ~w_full;
    assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

    assign w_push   = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_push & ~w_sel;
    assign m1_gnt_o = w_push &  w_sel;

    // ---------------------------------------------------------------
    // Response routing
    // ---------------------------------------------------------------
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_pop       = s_rvalid_i & (r_count != '0);
    assign m0_rvalid_o = w_pop & ~w_head;
    assign m1_rvalid_o = w_pop &  w_head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = r_err;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (s_req_o & ~s_gnt_i) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_sel;
        end else if (w_push) begin
            r_lock    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          r_err <= 1'b0;
        else if (s_rvalid_i & (r_count == '0)) r_err <= 1'b1;
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;

    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        m0_req, m1_req, m0_we, m1_we, s_gnt, s_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, err_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_o(err_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of requester IDs awaiting a response.
    int q[$];
    bit m_lock, m_lock_id, m_last, m_err;
    bit e_sreq, e_sel, e_g0, e_g1, e_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_lock = 0; m_lock_id = 0; m_last = 0; m_err = 0;
    endtask

    task automatic eval_check();
        e_sreq = (m0_req | m1_req) && (q.size() < MO);
        if (m_lock)              e_sel = m_lock_id;
        else if (m0_req != m1_req) e_sel = m1_req;
        else begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
            e_sel = !m_last;
`else
            e_sel = 1'b1;
`endif
        end
        e_g0  = s_gnt && e_sreq && !e_sel;
        e_g1  = s_gnt && e_sreq &&  e_sel;
        e_pop = s_rvalid && (q.size() > 0);
        chk("s_req", s_req_o, e_sreq);
        chk("m0_gnt", m0_gnt_o, e_g0);
        chk("m1_gnt", m1_gnt_o, e_g1);
        if (e_sreq) begin
            chk("s_addr",  s_addr_o,  e_sel ? m1_addr  : m0_addr);
            chk("s_we",    s_we_o,    e_sel ? m1_we    : m0_we);
            chk("s_be",    s_be_o,    e_sel ? m1_be    : m0_be);
            chk("s_wdata", s_wdata_o, e_sel ? m1_wdata : m0_wdata);
        end
        chk("m0_rvalid", m0_rvalid_o, e_pop && (q[0] == 0));
        chk("m1_rvalid", m1_rvalid_o, e_pop && (q[0] == 1));
        chk("m0_rdata", m0_rdata_o, s_rdata);
        chk("m1_rdata", m1_rdata_o, s_rdata);
        chk("err", err_o, m_err);
    endtask

    task automatic model_update();
        if (s_rvalid && q.size() == 0) m_err = 1;
        if (e_pop) void'(q.pop_front());
        if (e_sreq && s_gnt) begin
            q.push_back(int'(e_sel));
            m_last = e_sel;
            m_lock = 0;
        end else if (e_sreq) begin
            m_lock = 1;
            m_lock_id = e_sel;
        end
    endtask

    // One clock cycle: check at negedge, advance the model at posedge.
    task automatic cyc();
        @(negedge clk);
        eval_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #3;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_err", err_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_be = 4'hF; m1_be = 4'hF;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 0;
        model_reset();

        // Reset state
        #2 rst_ni = 1'b0;
        @(negedge clk);
        eval_check();
        m0_req = 1; m0_addr = 32'h55;
        #1;
        chk("rst_sreq_mirror", s_req_o, 1'b1);
        chk("rst_addr", s_addr_o, 32'h55);
        m0_req = 0;
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Single requester: grant then response one cycle later
        m0_req = 1; m0_addr = 32'h100; s_gnt = 1;
        #1 chk("single_gnt0", m0_gnt_o, 1'b1);
        cyc();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        #1;
        chk("single_rv0", m0_rvalid_o, 1'b1);
        chk("single_rdata", m0_rdata_o, 32'hDEADBEEF);
        chk("single_rv1", m1_rvalid_o, 1'b0);
        cyc();
        s_rvalid = 0;

        // Tie
        m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300; m1_we = 1; s_gnt = 1;
`ifndef OBI_ARB_ROUND_ROBIN_EN
        #1;
        chk("tie_gnt1", m1_gnt_o, 1'b1);
        chk("tie_addr", s_addr_o, 32'h300);
`endif
        cyc();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h1234_5678;
        cyc();
        s_rvalid = 0;

        // Lock: m0 waits 3 cycles, m1 joins in cycle 1
        m0_req = 1; m0_addr = 32'h400; m1_we = 0; s_gnt = 0;
        cyc();
        m1_req = 1; m1_addr = 32'h500;
        #1 chk("lock_addr1", s_addr_o, 32'h400);
        cyc();
        #1 chk("lock_addr2", s_addr_o, 32'h400);
        cyc();
        s_gnt = 1;
        #1 chk("lock_gnt_m0", m0_gnt_o, 1'b1);
        cyc();
        m0_req = 0;
        #1 chk("lock_gnt_m1", m1_gnt_o, 1'b1);
        cyc();

        // Backpressure: two outstanding (m0 then m1) -> full
        m1_req = 0; m0_req = 1; m0_addr = 32'h600;
        #1 chk("full_sreq", s_req_o, 1'b0);
        s_rvalid = 1; s_rdata = 32'hA5A5_0001;
        #1;
        chk("full_pop_sreq", s_req_o, 1'b0);
        chk("full_pop_rv0", m0_rvalid_o, 1'b1);
        cyc();
        s_rvalid = 0;
        #1 chk("resume_sreq", s_req_o, 1'b1);
        cyc();
        m0_req = 0; s_gnt = 0; s_rvalid = 1;
        #1 chk("order_rv1", m1_rvalid_o, 1'b1);
        cyc();
        #1 chk("order_rv0", m0_rvalid_o, 1'b1);
        cyc();

        // Spurious response
        #1;
        chk("spur_rv0", m0_rvalid_o, 1'b0);
        chk("spur_rv1", m1_rvalid_o, 1'b0);
        cyc();
        s_rvalid = 0;
        cyc();
        chk("spur_err_sticky", err_o, 1'b1);
        reset_pulse();

        // Reset mid-operation with one outstanding and a locked request
        m0_req = 1; m0_addr = 32'h700; s_gnt = 1;
        cyc();
        s_gnt = 0;
        cyc();
        #3;
        rst_ni = 1'b0;
        model_reset();
        m0_req = 0; m1_req = 1; m1_addr = 32'h800;
        #1;
        chk("midrst_sreq", s_req_o, 1'b1);
        chk("midrst_addr", s_addr_o, 32'h800);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        m1_req = 0; s_rvalid = 1;
        cyc();
        s_rvalid = 0;
        chk("late_rvalid_err", err_o, 1'b1);
        reset_pulse();

        // Randomized OBI-compliant traffic against the model
        e_g0 = 0; e_g1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!m0_req || e_g0) begin
                m0_req = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_we = 1'($urandom_range(0, 1));
                m0_be = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req || e_g1) begin
                m1_req = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_we = 1'($urandom_range(0, 1));
                m1_be = 4'($urandom); m1_wdata = $urandom;
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
